// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: issues a wide add/subtract one 64-bit slice per cycle
// to an external adder that has a single register stage. It chains the
// adder's registered carry-out into the next slice and assembles the wide
// result behind a valid/ready output port.
module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [64*WORDS-1:0]  in_a,
  input  logic [64*WORDS-1:0]  in_b,
  input  logic                 in_cin,
  input  logic                 in_sub,
  output logic [63:0]          add_a,
  output logic [63:0]          add_b,
  output logic                 add_cin,
  input  logic [63:0]          add_sum,
  input  logic                 add_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [64*WORDS-1:0]  out_sum,
  output logic                 out_cout
);

  localparam int W  = 64 * WORDS;
  localparam int CW = $clog2(WORDS + 1);
  localparam logic [CW-1:0] LAST = CW'(WORDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          cin0;

  assign in_ready = (state == IDLE);

  // Slice issue: while RUN has a slice left to send, present that slice; the
  // first slice takes the request carry, later ones chain the adder's carry.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      for (int k = 0; k < WORDS; k++) begin
        if (cnt == CW'(k)) begin
          add_a   = a_reg[k*64 +: 64];
          add_b   = b_reg[k*64 +: 64];
          add_cin = (k == 0) ? cin0 : add_cout;
        end
      end
    end
  end

  // Control FSM: latch the request, step through the slices capturing each
  // adder result one cycle after issue, then hold the result until taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      cin0      <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_sub ? ~in_b : in_b;
            cin0  <= in_sub ? 1'b1 : in_cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < WORDS; k++) begin
            if (cnt == CW'(k + 1)) begin
              out_sum[k*64 +: 64] <= add_sum;
            end
          end
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            out_cout  <= add_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: drives a 4-word sequencer and a 1-word sequencer,
// each with a one-stage registered 64-bit adder model behind it, and
// compares results against plain wide arithmetic.
module tb_wide_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 64 * WORDS;

  logic          clk;
  logic          rst;

  logic          in_valid, in_ready, in_cin, in_sub;
  logic [W-1:0]  in_a, in_b;
  logic [63:0]   add_a, add_b;
  logic          add_cin;
  logic [63:0]   add_sum = 64'hDEAD_BEEF_0BAD_F00D;
  logic          add_cout = 1'b1;
  logic          out_valid, out_ready, out_cout;
  logic [W-1:0]  out_sum;

  logic          in1_valid, in1_ready, in1_cin, in1_sub;
  logic [63:0]   in1_a, in1_b;
  logic [63:0]   add1_a, add1_b;
  logic          add1_cin;
  logic [63:0]   add1_sum = 64'hFEED_FACE_1234_5678;
  logic          add1_cout = 1'b1;
  logic          out1_valid, out1_ready, out1_cout;
  logic [63:0]   out1_sum;

  int tests_run;
  int tests_failed;

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
  );

  wide_add_sequencer #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in1_valid), .in_ready(in1_ready),
    .in_a(in1_a), .in_b(in1_b), .in_cin(in1_cin), .in_sub(in1_sub),
    .add_a(add1_a), .add_b(add1_b), .add_cin(add1_cin),
    .add_sum(add1_sum), .add_cout(add1_cout),
    .out_valid(out1_valid), .out_ready(out1_ready),
    .out_sum(out1_sum), .out_cout(out1_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-register-stage 64-bit adders standing in for the downstream stage
  always @(posedge clk) {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + 65'(add_cin);
  always @(posedge clk) {add1_cout, add1_sum} <= {1'b0, add1_a} + {1'b0, add1_b} + 65'(add1_cin);

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [263:0] observed, input logic [263:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Carry entering slice j = carry out of the low 64*j bits of the sum
  function automatic logic carryInto(input logic [W-1:0] a, input logic [W-1:0] bp,
                                     input logic c0, input int j);
    logic [W-1:0] mask;
    logic [W:0]   low;
    if (j == 0) return c0;
    mask = {W{1'b1}} >> (W - 64 * j);
    low  = {1'b0, a & mask} + {1'b0, bp & mask} + (W+1)'(c0);
    return low[64 * j];
  endfunction

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub, input int hold_cycles);
    logic [W-1:0] bp;
    logic         c0;
    logic [W:0]   exp_full;
    logic [128:0] exp_issue;
    bp       = sub ? ~b : b;
    c0       = sub ? 1'b1 : cin;
    exp_full = {1'b0, a} + {1'b0, bp} + (W+1)'(c0);
    checkOutput("in_ready_idle", 264'(in_ready), 264'(1'b1));
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = rand256(); in_b = rand256(); in_cin = $urandom_range(0, 1); in_sub = $urandom_range(0, 1);
    for (int j = 0; j <= WORDS; j++) begin
      if (j < WORDS) exp_issue = {carryInto(a, bp, c0, j), bp[64*j +: 64], a[64*j +: 64]};
      else           exp_issue = '0;
      checkOutput("issue_slice", 264'({add_cin, add_b, add_a}), 264'(exp_issue));
      checkOutput("run_flags", 264'({out_valid, in_ready}), 264'(2'b00));
      tick();
    end
    checkOutput("latency_valid", 264'(out_valid), 264'(1'b1));
    checkOutput("result", 264'({out_cout, out_sum}), 264'(exp_full));
    checkOutput("done_adder_idle", 264'({add_cin, add_b, add_a}), 264'(0));
    for (int h = 0; h < hold_cycles; h++) begin
      in_valid = h[0] ? 1'b0 : 1'b1;
      in_a = rand256();
      tick();
      checkOutput("hold_flags", 264'({out_valid, in_ready}), 264'(2'b10));
      checkOutput("hold_result", 264'({out_cout, out_sum}), 264'(exp_full));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("release_flags", 264'({out_valid, in_ready}), 264'(2'b01));
  endtask

  task automatic oneWordTest(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
    logic [64:0] exp_full;
    exp_full = sub ? ({1'b0, a} + {1'b0, ~b} + 65'd1) : ({1'b0, a} + {1'b0, b} + 65'(cin));
    checkOutput("w1_ready", 264'(in1_ready), 264'(1'b1));
    in1_a = a; in1_b = b; in1_cin = cin; in1_sub = sub; in1_valid = 1'b1;
    tick();
    in1_valid = 1'b0;
    checkOutput("w1_issue", 264'({add1_cin, add1_b, add1_a}), 264'({sub ? 1'b1 : cin, sub ? ~b : b, a}));
    checkOutput("w1_cnt0_valid", 264'(out1_valid), 264'(1'b0));
    tick();
    checkOutput("w1_cnt1_valid", 264'(out1_valid), 264'(1'b0));
    tick();
    checkOutput("w1_latency_valid", 264'(out1_valid), 264'(1'b1));
    checkOutput("w1_result", 264'({out1_cout, out1_sum}), 264'(exp_full));
    out1_ready = 1'b1;
    tick();
    out1_ready = 1'b0;
    checkOutput("w1_release", 264'({out1_valid, in1_ready}), 264'(2'b01));
  endtask

  task automatic resetMidRun();
    in_a = rand256(); in_b = rand256(); in_cin = 1'b1; in_sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_flags", 264'({out_valid, in_ready}), 264'(2'b01));
    checkOutput("rst_adder", 264'({add_cin, add_b, add_a}), 264'(0));
    checkOutput("rst_result", 264'({out_cout, out_sum}), 264'(0));
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [W-1:0] pat;
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
    in1_valid = 1'b0; in1_a = '0; in1_b = '0; in1_cin = 1'b0; in1_sub = 1'b0; out1_ready = 1'b0;
    #2;
    checkOutput("reset_flags", 264'({out_valid, in_ready}), 264'(2'b01));
    checkOutput("reset_adder", 264'({add_cin, add_b, add_a}), 264'(0));
    checkOutput("reset_result", 264'({out_cout, out_sum}), 264'(0));
    #1;
    rst = 1'b1;
    tick();

    applyStimulus({W{1'b1}}, '0, 1'b1, 1'b0, 0);
    applyStimulus('0, W'(1), 1'b0, 1'b1, 0);
    pat = {WORDS{64'h0123_4567_89AB_CDEF}};
    applyStimulus(pat, pat, 1'b0, 1'b1, 1);
    applyStimulus(W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1) << 128, 1'b0, 1'b0, 0);
    applyStimulus(rand256(), rand256(), 1'b1, 1'b0, 3);

    resetMidRun();
    applyStimulus(W'(5), W'(7), 1'b0, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(rand256(), rand256(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)));
    end

    oneWordTest(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
    oneWordTest(64'h0, 64'h1, 1'b0, 1'b1);
    oneWordTest({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
Multi-word add/subtract sequencer that sits directly upstream of the registered 64-bit conditional-sum adder stage (Con_sa_64) and consumes its registered result one cycle later. It accepts a wide operand pair through a valid/ready handshake and issues one 64-bit slice per cycle to the adder. Each slice's carry-in is the adder's registered carry-out from the previous slice. The assembled wide result is held on a valid/ready output port until the consumer takes it.

Parameters:
WORDS, 4, number of 64-bit slices; operand width = 64*WORDS; legal range WORDS >= 1.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
in_valid  input  1  operand request valid.
in_ready  output  1  sequencer can accept a request.
in_a  input  64*WORDS  operand A.
in_b  input  64*WORDS  operand B.
in_cin  input  1  carry-in for add; ignored when in_sub=1.
in_sub  input  1  1 = compute A-B, 0 = compute A+B+in_cin.
add_a  output  64  slice of A to the adder's a input.
add_b  output  64  slice of B' to the adder's b input.
add_cin  output  1  to the adder's cin input.
add_sum  input  64  adder's registered sum_r.
add_cout  input  1  adder's registered cout_r.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_sum  output  64*WORDS  wide result.
out_cout  output  1  final carry; for subtract, 1 = no borrow (A >= B unsigned).

Behaviour:
- Reset (rst=0, asynchronous):
  - State is IDLE and cnt = 0.
  - Operand registers, out_sum, out_cout, out_valid, add_a, add_b and add_cin are all 0.
  - in_ready is 1 from the moment reset asserts.
- Adder contents: any value left in the adder's registers before the first issue is never captured.
- FSM states: IDLE, RUN, DONE. Counter cnt has width clog2(WORDS+1).
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid=1, latch A and B' = in_sub ? ~in_b : in_b.
  - Latch cin0 = in_sub ? 1 : in_cin.
  - Set cnt = 0 and go to RUN.
- RUN (in_ready = 0; in_valid is ignored):
  - cnt = 0: add_a = A[63:0], add_b = B'[63:0], add_cin = cin0. No capture.
  - 1 <= cnt <= WORDS-1:
    - Capture add_sum into out_sum slice cnt-1.
    - Drive add_a = A slice cnt and add_b = B' slice cnt.
    - add_cin = add_cout, combinational pass-through within the same cycle.
  - cnt = WORDS:
    - Capture add_sum into slice WORDS-1 and latch out_cout = add_cout.
    - Drive add_a, add_b, add_cin to 0.
    - Go to DONE.
  - cnt increments each cycle.
- Adder interface outside RUN: add_a, add_b, add_cin are driven to 0 in IDLE, in DONE, and in the RUN cnt=WORDS cycle.
- Slice indexing: slice k = bits [64k+63:64k].
- Latency: out_valid rises WORDS+1 cycles after the accepting edge (5 cycles for WORDS=4). This relies on the adder having exactly one register stage.
- DONE:
  - out_valid = 1; out_sum and out_cout are held stable.
  - On an edge with out_ready=1, clear out_valid and go to IDLE.
  - No new request is accepted on that same edge; minimum initiation interval is WORDS+3 cycles.
- Backpressure: out_ready=0 holds DONE indefinitely with stable outputs.
- Arithmetic:
  - Result is modulo 2^(64*WORDS).
  - Add: out_cout = carry out of bit 64*WORDS-1.
  - Subtract: two's complement A + ~B + 1.
- Reset mid-operation: an asynchronous reset in any state returns to IDLE immediately and discards the partial result. The first request after reset completes correctly.
- WORDS=1: RUN lasts 2 cycles (cnt 0, 1); latency is 2.

Test Plan:
1. WORDS=4, A=all ones (256 bits), B=0, cin=1, add -> out_sum=0, out_cout=1; out_valid exactly 5 cycles after accept; add_cin=1 on slices 1-3.
2. Subtract A=0, B=1 -> out_sum=all ones, out_cout=0; then subtract A=B=0x0123..CDEF repeated -> out_sum=0, out_cout=1.
3. Add A=2^64-1, B=2^128 -> out_sum=0x1_0000000000000000_FFFFFFFFFFFFFFFF, out_cout=0; no spurious carry into slice 1.
4. Hold out_ready=0 for 3 cycles after out_valid -> out_sum/out_cout stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE, next request accepted one cycle later.
5. Assert rst during RUN at cnt=2 -> out_valid=0, in_ready=1, add_* = 0 asynchronously; a subsequent add 5+7 -> out_sum=12, out_cout=0.
6. WORDS=1 build, add A=B=0x8000000000000000 -> out_sum=0, out_cout=1, latency 2 cycles.
